pe_ws_db: RTL and testbench

//  Parametrised weight-stationary systolic PE with double-buffered (shadow/active) weights.

---
 rtl/pe_ws_db_pkg.sv | 16 +
 rtl/pe_ws_db_if.sv | 20 ++
 rtl/pe_ws_db_mac_sat.sv | 39 +++
 rtl/pe_ws_db.sv | 105 ++++++++++
 tb/tb_pe_ws_db.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ws_db_pkg.sv
// Shared definitions for the weight-stationary PE with double-buffered weights.
//   DATA_W_DEF / ACC_W_DEF : default activation/weight and partial-sum widths
//   data_t / acc_t         : signed types at the default widths
//   ACC_MAX / ACC_MIN      : saturation limits at the default accumulator width
package pe_ws_db_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;

  typedef logic signed [DATA_W_DEF-1:0] data_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/pe_ws_db_if.sv
// Beat bus between neighbouring PEs: one activation/partial-sum beat per cycle.
//   valid : qualifies a, psum, sat and sw for this beat
//   a     : activation (left -> right)
//   psum  : partial sum (top -> bottom)
//   sat   : saturation flag travelling with psum
//   sw    : switch token promoting shadow -> active weight for this beat
// master drives the bus, slave receives it. No backpressure exists.
interface pe_ws_db_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic              valid;
  logic [DATA_W-1:0] a;
  logic [ACC_W-1:0]  psum;
  logic              sat;
  logic              sw;

  modport master (output valid, a, psum, sat, sw);
  modport slave  (input  valid, a, psum, sat, sw);
endinterface

// File: rtl/pe_ws_db_mac_sat.sv
// Combinational multiply-accumulate with optional saturation.
//   i_a, i_w : signed activation and effective weight (DATA_W)
//   i_psum   : signed incoming partial sum (ACC_W)
//   o_sum    : psum + a*w, clamped when SAT=1, wrapped when SAT=0
//   o_ovf    : the exact sum did not fit in ACC_W (flagged for both SAT modes)
module pe_ws_db_mac_sat
  import pe_ws_db_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT    = 1'b1
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [ACC_W-1:0]  i_psum,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
    if (s[ACC_W]) return {1'b1, {(ACC_W-1){1'b0}}};
    else          return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W:0]    w_prod_x;
  logic signed [ACC_W:0]    w_sum_x;

  assign w_prod   = i_a * i_w;
  assign w_prod_x = {{EXT_W{w_prod[PROD_W-1]}}, w_prod};
  // One guard bit makes the sum exact; overflow shows as guard != sign.
  assign w_sum_x  = {i_psum[ACC_W-1], i_psum} + w_prod_x;
  assign o_ovf    = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];
  assign o_sum    = (SAT && o_ovf) ? sat_clamp(w_sum_x) : w_sum_x[ACC_W-1:0];

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary systolic PE with shadow/active weight double buffering.
//   clk, reset   : clock, synchronous active-high reset
//   in_bus       : beat from left/upper neighbours (slave)
//   out_bus      : registered beat to right/lower neighbours (master), 1-cycle latency
//   weight_shift : column-wide load of weight_in into the shadow register
//   weight_in    : weight from the upper PE's weight_out or the column feeder
//   weight_out   : current shadow register, forms the column shift chain
//   switch_err   : sticky, a switch arrived while the shadow was empty
module pe_ws_db
  import pe_ws_db_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  pe_ws_db_if.slave         in_bus,
  pe_ws_db_if.master        out_bus,
  input  logic              weight_shift,
  input  logic [DATA_W-1:0] weight_in,
  output logic [DATA_W-1:0] weight_out,
  output logic              switch_err
);

  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_a_p1;
  logic signed [ACC_W-1:0]  r_psum_p1;
  logic                     r_sat_p1;
  logic                     r_sw_p1;
  logic signed [DATA_W-1:0] r_active_w;
  logic signed [DATA_W-1:0] r_shadow_w;
  logic                     r_shadow_full;
  logic                     r_switch_err;

  logic                     w_do_switch;
  logic                     w_promote;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_eff;
  logic signed [ACC_W-1:0]  w_psum_in;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_ovf;

  // Stage p0: effective weight selection and MAC. The switch beat already
  // multiplies by the shadow weight, so promotion costs no bubble.
  assign w_do_switch = in_bus.valid & in_bus.sw;
  assign w_promote   = w_do_switch & r_shadow_full;
  assign w_eff       = w_promote ? r_shadow_w : r_active_w;
  assign w_a         = in_bus.a;
  assign w_psum_in   = in_bus.psum;

  pe_ws_db_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT    (SAT)
  ) u_mac (
    .i_a    (w_a),
    .i_w    (w_eff),
    .i_psum (w_psum_in),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // Stage p1: output beat registers and weight buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1      <= 1'b0;
      r_a_p1        <= '0;
      r_psum_p1     <= '0;
      r_sat_p1      <= 1'b0;
      r_sw_p1       <= 1'b0;
      r_active_w    <= '0;
      r_shadow_w    <= '0;
      r_shadow_full <= 1'b0;
      r_switch_err  <= 1'b0;
    end else begin
      r_vld_p1 <= in_bus.valid;
      r_sw_p1  <= w_do_switch;
      if (in_bus.valid) begin
        r_a_p1    <= w_a;
        r_psum_p1 <= w_sum;
        r_sat_p1  <= in_bus.sat | w_ovf;
      end
      if (w_promote) r_active_w <= r_shadow_w;
      if (w_do_switch && !r_shadow_full) r_switch_err <= 1'b1;
      // A shift in the same cycle as a promotion refills the shadow,
      // so the load wins over the clear.
      if (weight_shift) begin
        r_shadow_w    <= weight_in;
        r_shadow_full <= 1'b1;
      end else if (w_promote) begin
        r_shadow_full <= 1'b0;
      end
    end
  end

  assign out_bus.valid = r_vld_p1;
  assign out_bus.a     = r_a_p1;
  assign out_bus.psum  = r_psum_p1;
  assign out_bus.sat   = r_sat_p1;
  assign out_bus.sw    = r_sw_p1;
  assign weight_out    = r_shadow_w;
  assign switch_err    = r_switch_err;

endmodule

// File: tb/tb_pe_ws_db.sv
// Bench for pe_ws_db: one saturating and one wrapping instance share the same
// stimulus; a behavioural model predicts both every cycle.
module tb_pe_ws_db;
  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          weight_shift;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] wout_s, wout_w;
  logic          err_s, err_w;

  int n_chk  = 0;
  int n_fail = 0;

  pe_ws_db_if #(.DATA_W(DW), .ACC_W(AW)) in_bus ();
  pe_ws_db_if #(.DATA_W(DW), .ACC_W(AW)) out_s ();
  pe_ws_db_if #(.DATA_W(DW), .ACC_W(AW)) out_w ();

  pe_ws_db #(.DATA_W(DW), .ACC_W(AW), .SAT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_bus(in_bus), .out_bus(out_s),
    .weight_shift(weight_shift), .weight_in(weight_in),
    .weight_out(wout_s), .switch_err(err_s)
  );

  pe_ws_db #(.DATA_W(DW), .ACC_W(AW), .SAT(1'b0)) dut_w (
    .clk(clk), .reset(reset), .in_bus(in_bus), .out_bus(out_w),
    .weight_shift(weight_shift), .weight_in(weight_in),
    .weight_out(wout_w), .switch_err(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_act, m_shd;
  bit            m_full, m_err;
  bit            e_vld, e_sw, e_sat_s, e_sat_w;
  logic [DW-1:0] e_a;
  logic [AW-1:0] e_ps_s, e_ps_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input bit sh,
                       input logic [DW-1:0] wi, input logic [DW-1:0] a,
                       input logic [AW-1:0] ps, input bit si);
    longint full, lim_hi, lim_lo;
    logic [DW-1:0] weff;
    bit do_sw, prom, ovf;
    lim_hi = 64'sd2147483647;
    lim_lo = -64'sd2147483648;
    if (r) begin
      m_act = '0; m_shd = '0; m_full = 0; m_err = 0;
      e_vld = 0; e_sw = 0; e_sat_s = 0; e_sat_w = 0;
      e_a = '0; e_ps_s = '0; e_ps_w = '0;
      return;
    end
    do_sw = v && s;
    prom  = do_sw && m_full;
    weff  = prom ? m_shd : m_act;
    e_vld = v;
    e_sw  = do_sw;
    if (v) begin
      full = longint'($signed(ps)) + longint'($signed(a)) * longint'($signed(weff));
      ovf  = (full > lim_hi) || (full < lim_lo);
      e_ps_w  = full[31:0];
      e_ps_s  = !ovf ? full[31:0] : (full < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF);
      e_sat_s = si | ovf;
      e_sat_w = si | ovf;
      e_a     = a;
    end
    if (do_sw && !m_full) m_err = 1;
    if (prom) m_act = m_shd;
    if (sh) begin
      m_shd  = wi;
      m_full = 1;
    end else if (prom) begin
      m_full = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".vld_s"},  {31'd0, out_s.valid}, {31'd0, e_vld});
    check({tag, ".vld_w"},  {31'd0, out_w.valid}, {31'd0, e_vld});
    check({tag, ".a_s"},    {16'd0, out_s.a},     {16'd0, e_a});
    check({tag, ".a_w"},    {16'd0, out_w.a},     {16'd0, e_a});
    check({tag, ".sw_s"},   {31'd0, out_s.sw},    {31'd0, e_sw});
    check({tag, ".sw_w"},   {31'd0, out_w.sw},    {31'd0, e_sw});
    check({tag, ".psum_s"}, out_s.psum,           e_ps_s);
    check({tag, ".psum_w"}, out_w.psum,           e_ps_w);
    check({tag, ".sat_s"},  {31'd0, out_s.sat},   {31'd0, e_sat_s});
    check({tag, ".sat_w"},  {31'd0, out_w.sat},   {31'd0, e_sat_w});
    check({tag, ".wout_s"}, {16'd0, wout_s},      {16'd0, m_shd});
    check({tag, ".wout_w"}, {16'd0, wout_w},      {16'd0, m_shd});
    check({tag, ".err_s"},  {31'd0, err_s},       {31'd0, m_err});
    check({tag, ".err_w"},  {31'd0, err_w},       {31'd0, m_err});
  endtask

  task automatic step(input string tag, input bit r, input bit v, input bit s, input bit sh,
                      input logic [DW-1:0] wi, input logic [DW-1:0] a,
                      input logic [AW-1:0] ps, input bit si);
    reset        = r;
    in_bus.valid = v;
    in_bus.sw    = s;
    in_bus.a     = a;
    in_bus.psum  = ps;
    in_bus.sat   = si;
    weight_shift = sh;
    weight_in    = wi;
    model(r, v, s, sh, wi, a, ps, si);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 16'h0, 16'h0, 32'h0, 0);
  endtask

  task automatic do_reset();
    step("rst", 1, 0, 0, 0, 16'h0, 16'h0, 32'h0, 0);
  endtask

  initial begin
    logic [DW-1:0] ra, rw;
    logic [AW-1:0] rp;
    reset = 1; in_bus.valid = 0; in_bus.sw = 0; in_bus.a = '0;
    in_bus.psum = '0; in_bus.sat = 0; weight_shift = 0; weight_in = '0;
    @(posedge clk); #1;

    // Reset state with busy inputs applied
    step("reset_busy", 1, 1, 1, 1, 16'h1234, 16'h7777, 32'h5555_5555, 1);
    check("reset.psum", out_s.psum, 32'h0);
    check("reset.valid", {31'd0, out_s.valid}, 32'd0);

    // Shift 3, then switch beat a=5 psum=10 -> 25
    step("shift3", 0, 0, 0, 1, 16'd3, 16'd0, 32'd0, 0);
    step("sw_beat", 0, 1, 1, 0, 16'd0, 16'd5, 32'd10, 0);
    check("sc1.psum", out_s.psum, 32'd25);
    check("sc1.a", {16'd0, out_s.a}, 32'd5);
    check("sc1.valid", {31'd0, out_s.valid}, 32'd1);
    check("sc1.switch", {31'd0, out_s.sw}, 32'd1);
    // Hold on idle beat, switch ignored without valid
    step("hold", 0, 0, 1, 0, 16'd0, 16'd9, 32'd99, 0);
    check("hold.psum", out_s.psum, 32'd25);
    check("hold.switch", {31'd0, out_s.sw}, 32'd0);
    step("active3", 0, 1, 0, 0, 16'd0, 16'd2, 32'd1, 0);
    check("active3.psum", out_s.psum, 32'd7);

    // Switch with empty shadow: computed with active=0, sticky error
    do_reset();
    step("sw_empty", 0, 1, 1, 0, 16'd0, 16'd5, 32'd10, 0);
    check("sc2.psum", out_s.psum, 32'd10);
    check("sc2.err", {31'd0, err_s}, 32'd1);
    for (int i = 0; i < 3; i++) idle("sc2_sticky");
    check("sc2.err_sticky", {31'd0, err_w}, 32'd1);

    // Overflow: both saturating and wrapping flavours
    do_reset();
    step("shift7fff", 0, 0, 0, 1, 16'h7FFF, 16'd0, 32'd0, 0);
    step("ovf", 0, 1, 1, 0, 16'd0, 16'h7FFF, 32'h7FFF_FFFF, 0);
    check("sc3.psum_sat", out_s.psum, 32'h7FFF_FFFF);
    check("sc3.sat_sat", {31'd0, out_s.sat}, 32'd1);
    check("sc3.psum_wrap", out_w.psum, 32'hBFFF_0000);
    check("sc3.sat_wrap", {31'd0, out_w.sat}, 32'd1);
    step("neg_ovf", 0, 1, 0, 0, 16'd0, 16'h8000, 32'h8000_0000, 0);
    check("sc3.psum_min", out_s.psum, 32'h8000_0000);

    // Shift and switch in the same cycle
    do_reset();
    step("shift7", 0, 0, 0, 1, 16'd7, 16'd0, 32'd0, 0);
    step("shift9_sw", 0, 1, 1, 1, 16'd9, 16'd1, 32'd0, 0);
    check("sc4.psum", out_s.psum, 32'd7);
    check("sc4.wout", {16'd0, wout_s}, 32'd9);
    step("sw_again", 0, 1, 1, 0, 16'd0, 16'd1, 32'd0, 0);
    check("sc4.psum9", out_s.psum, 32'd9);
    check("sc4.err", {31'd0, err_s}, 32'd0);

    // Negative operands
    do_reset();
    step("shiftm2", 0, 0, 0, 1, 16'hFFFE, 16'd0, 32'd0, 0);
    step("neg", 0, 1, 1, 0, 16'd0, 16'd3, 32'hFFFF_FFFC, 0);
    check("sc5.psum", out_s.psum, 32'hFFFF_FFF6);
    check("sc5.sat", {31'd0, out_s.sat}, 32'd0);
    step("sat_in", 0, 1, 0, 0, 16'd0, 16'd1, 32'd0, 1);
    check("sc5.sat_in", {31'd0, out_w.sat}, 32'd1);

    // Reset in the middle of a valid beat
    step("pre_err", 0, 1, 1, 0, 16'd0, 16'd1, 32'd1, 0);
    step("rst_mid", 1, 1, 1, 1, 16'd5, 16'd4, 32'd4, 1);
    check("sc6.psum", out_s.psum, 32'd0);
    check("sc6.err", {31'd0, err_s}, 32'd0);
    step("post_rst_sw", 0, 1, 1, 0, 16'd0, 16'd4, 32'd4, 0);
    check("sc6.full_cleared", {31'd0, err_s}, 32'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rw = 16'($urandom);
      rp = $urandom;
      if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      if ($urandom_range(0, 4) == 0) rw = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           rw, ra, rp, ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
